// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Response latency is held in a 4-bit down-counter.
    localparam int CNT_W       = 4;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } mem_kind_t;

endpackage

// File: rtl/data_mem_if.sv
// Load/store bus between the execute stage (master) and the data memory (slave).
//
// Handshake rules: the master raises i_wr_valid (write) or i_rd_ready (read)
// and holds it, with address/data/enables stable, until the slave answers.
// The slave answers with o_wr_ready (write committed) or o_rd_valid (read data
// on o_data) and holds the answer, o_data and o_err stable until the cycle the
// master's request line is also high; that cycle is the handshake and the
// answer drops on the following edge. The master must release its request
// right after the handshake edge or it is taken as a new request.
interface data_mem_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]             i_addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic                    i_wr_valid;
    logic                    o_wr_ready;
    logic [DATA_WIDTH/8-1:0] i_byte_write_enable;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_rd_valid;
    logic                    i_rd_ready;
    logic                    o_err;

    modport master (
        output i_addr, i_data, i_wr_valid, i_byte_write_enable, i_rd_ready,
        input  o_wr_ready, o_data, o_rd_valid, o_err
    );

    modport slave (
        input  i_addr, i_data, i_wr_valid, i_byte_write_enable, i_rd_ready,
        output o_wr_ready, o_data, o_rd_valid, o_err
    );
endinterface

// File: rtl/data_mem_mem_array.sv
// Single-port byte-enabled RAM with a registered read port. Contents are not
// reset; the read register only changes on an enabled read.
module mem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Enabled write updates the selected byte lanes; enabled read loads rdata.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (be[b]) begin
                        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: accepts one load or store at a time, waits LATENCY
// cycles, then presents the response until the initiator handshakes it.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int          DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    data_mem_if.slave  bus,
    output mem_state_t dbg_state
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          BE_W  = DATA_WIDTH / 8;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_mem: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    mem_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    mem_kind_t         kind_q;
    logic [31:0]       addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;

    logic              req;
    logic              accept;
    logic              handshake;
    logic              commit;
    mem_kind_t         req_kind;
    mem_kind_t         cur_kind;
    logic [31:0]       cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [BE_W-1:0]   cur_be;
    logic [32:0]       offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req       = bus.i_wr_valid | bus.i_rd_ready;
    assign req_kind  = bus.i_wr_valid ? WR : RD;
    assign accept    = (state == IDLE) && req;
    assign handshake = (state == RESP) &&
                       ((kind_q == WR) ? bus.i_wr_valid : bus.i_rd_ready);

    // With LATENCY==1 the edge into RESP is the accept edge, so the request is
    // taken straight from the bus; otherwise it comes from the latches.
    assign cur_kind = (state == IDLE) ? req_kind           : kind_q;
    assign cur_addr = (state == IDLE) ? bus.i_addr          : addr_q;
    assign cur_data = (state == IDLE) ? bus.i_data          : data_q;
    assign cur_be   = (state == IDLE) ? bus.i_byte_write_enable : be_q;

    // Storage is touched only on the edge into RESP; a reset in flight
    // suppresses it so an abandoned write never lands.
    assign commit = ~i_rst & ((accept && (LATENCY == 1)) ||
                              ((state == BUSY) && (cnt == CNT_W'(1))));

    // 33-bit offset: an address below BASE_ADDR wraps into the top bit and
    // so fails the span compare as well.
    assign offset   = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign in_range = (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clk  (i_clk),
        .en   (commit & in_range),
        .we   (cur_kind == WR),
        .be   (cur_be),
        .idx  (idx),
        .wdata(cur_data),
        .rdata(ram_rdata)
    );

    // State register and latency counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state: accept, count down the latency, wait for the handshake.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = BUSY;
                        cnt_n   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (handshake) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latches on accept; error flag captured on the edge into RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            kind_q <= RD;
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                kind_q <= req_kind;
                addr_q <= bus.i_addr;
                data_q <= bus.i_data;
                be_q   <= bus.i_byte_write_enable;
            end
            if (commit) begin
                err_q <= ~in_range;
            end
        end
    end

    // Responses are decoded from registered state only, so they are clean and
    // fall to zero as soon as the FSM leaves RESP or reset is applied.
    assign bus.o_wr_ready = (state == RESP) && (kind_q == WR);
    assign bus.o_rd_valid = (state == RESP) && (kind_q == RD);
    assign bus.o_err      = (state == RESP) && err_q;
    assign bus.o_data     = ((state == RESP) && (kind_q == RD) && !err_q) ? ram_rdata : '0;
    assign dbg_state      = state;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: three instances (LATENCY 1, 3, 4) share one
// set of request signals, and sel routes the request lines to one of them.
module tb_data_mem;
    import data_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared request side ----------------
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr_valid;
    logic        rd_ready;
    int          sel;

    logic        wr_ready_a [3];
    logic        rd_valid_a [3];
    logic        err_a      [3];
    logic [31:0] data_a     [3];
    mem_state_t  st_a       [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_if #(.DATA_WIDTH(32)) bus ();
        assign bus.i_addr              = addr;
        assign bus.i_data              = wdata;
        assign bus.i_byte_write_enable = be;
        assign bus.i_wr_valid          = wr_valid && (sel == g);
        assign bus.i_rd_ready          = rd_ready && (sel == g);
        assign wr_ready_a[g]           = bus.o_wr_ready;
        assign rd_valid_a[g]           = bus.o_rd_valid;
        assign err_a[g]                = bus.o_err;
        assign data_a[g]               = bus.o_data;

        data_mem #(
            .DATA_WIDTH (32),
            .DEPTH_WORDS(1024),
            .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .BASE_ADDR  (32'h0000_0000)
        ) dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .bus      (bus),
            .dbg_state(st_a[g])
        );
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] any_out(input int s);
        return 32'(wr_ready_a[s] | rd_valid_a[s] | err_a[s] | (data_a[s] != 32'h0));
    endfunction

    // ---------------- driver ----------------
    // One complete transaction on the selected instance: request after an edge
    // (cycle 0), count cycles until the response, handshake, check the drop.
    task automatic txn(input string name, input bit is_wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input int lat,
                       input logic [31:0] exp_d, input bit exp_e);
        int k;
        bit seen;
        if (!is_wr) exp_q.push_back(exp_d);
        @(posedge clk); #1;
        addr = a; wdata = d; be = b;
        wr_valid = is_wr; rd_ready = !is_wr;
        k = 0; seen = 1'b0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            if (is_wr ? wr_ready_a[sel] : rd_valid_a[sel]) seen = 1'b1;
            else k++;
        end
        check({name, " latency"}, 32'(k), 32'(lat));
        check({name, " other"}, 32'(is_wr ? rd_valid_a[sel] : wr_ready_a[sel]), 32'd0);
        check({name, " err"}, 32'(err_a[sel]), 32'(exp_e));
        if (!is_wr) check({name, " data"}, data_a[sel], exp_q.pop_front());
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        check({name, " drop"}, any_out(sel), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t tab [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Byte writes put the byte on its own lane of i_data.
        tab[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0};
        tab[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
        tab[2]  = '{1'b1, 32'h0000_0010, 32'h00AA_0000, 4'b0100, 32'h0, 1'b0};
        tab[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAA_BEEF, 1'b0};
        tab[4]  = '{1'b1, 32'h0000_0013, 32'h1122_3344, 4'b0011, 32'h0, 1'b0};
        tab[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAA_3344, 1'b0};
        tab[6]  = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0};
        tab[7]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0};
        tab[8]  = '{1'b0, 32'h0000_0014, 32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0};
        tab[9]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0};
        tab[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'h0, 1'b1};
        tab[11] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h0, 1'b1};
        tab[12] = '{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0};
        tab[13] = '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'b1111, 32'h0, 1'b0};
        tab[14] = '{1'b0, 32'h0000_0FFE, 32'h0,         4'b0000, 32'h5A5A_5A5A, 1'b0};
        tab[15] = '{1'b1, 32'h0000_1FFC, 32'h0000_0000, 4'b1111, 32'h0, 1'b1};
        tab[16] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'h5A5A_5A5A, 1'b0};
        tab[17] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0, 1'b1};

        // ---- reset ----
        rst = 1'b1; addr = '0; wdata = '0; be = '0; wr_valid = 1'b0; rd_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset outputs dut%0d", g), any_out(g), 32'd0);
            check($sformatf("reset state dut%0d", g), 32'(st_a[g]), 32'(IDLE));
        end
        rst = 1'b0;

        // ---- table, LATENCY=1 ----
        sel = 0;
        for (int i = 0; i < 18; i++) begin
            txn($sformatf("vec%0d", i), tab[i].wr, tab[i].a, tab[i].d, tab[i].be,
                1, tab[i].exp_d, tab[i].exp_e);
        end

        // ---- simultaneous write and read: write first, read sees new data ----
        @(posedge clk); #1;
        addr = 32'h20; wdata = 32'h1357_9BDF; be = 4'hF; wr_valid = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        check("both c0 idle", any_out(0), 32'd0);
        @(negedge clk);
        check("both c1 wr_ready", 32'(wr_ready_a[0]), 32'd1);
        check("both c1 rd_valid", 32'(rd_valid_a[0]), 32'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("both c2 gap", any_out(0), 32'd0);
        check("both c2 state", 32'(st_a[0]), 32'(IDLE));
        @(negedge clk);
        check("both c3 rd_valid", 32'(rd_valid_a[0]), 32'd1);
        check("both c3 data", data_a[0], 32'h1357_9BDF);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        @(negedge clk);
        check("both c4 drop", any_out(0), 32'd0);

        // ---- LATENCY=4: back-to-back reads with i_rd_ready held ----
        sel = 2;
        txn("l4 write", 1'b1, 32'h40, 32'h600D_CAFE, 4'hF, 4, 32'h0, 1'b0);
        @(posedge clk); #1;
        addr = 32'h40; rd_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            check($sformatf("l4 rd_valid c%0d", c), 32'(rd_valid_a[2]), 32'((c == 4) || (c == 9)));
            if (c == 4 || c == 9) check($sformatf("l4 data c%0d", c), data_a[2], 32'h600D_CAFE);
        end
        rd_ready = 1'b0;

        // ---- LATENCY=4: write withdrawn during BUSY still commits ----
        @(posedge clk); #1;
        addr = 32'h44; wdata = 32'h0F0F_0F0F; be = 4'hF; wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0; addr = 32'hDEAD_0000; wdata = 32'h0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("wd wr_ready c%0d", c), 32'(wr_ready_a[2]), 32'(c >= 4));
        end
        check("wd err", 32'(err_a[2]), 32'd0);
        wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("wd drop", any_out(2), 32'd0);
        txn("wd read", 1'b0, 32'h44, 32'h0, 4'h0, 4, 32'h0F0F_0F0F, 1'b0);

        // ---- LATENCY=3: reset during BUSY abandons the write ----
        sel = 1;
        txn("l3 old", 1'b1, 32'h20, 32'h1111_1111, 4'hF, 3, 32'h0, 1'b0);
        @(posedge clk); #1;
        addr = 32'h20; wdata = 32'h2222_2222; be = 4'hF; wr_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst busy state", 32'(st_a[1]), 32'(BUSY));
        rst = 1'b1;
        #1;
        check("rst busy outputs", any_out(1), 32'd0);
        check("rst busy idle", 32'(st_a[1]), 32'(IDLE));
        wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txn("l3 after rst", 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h1111_1111, 1'b0);

        // ---- LATENCY=3: reset during RESP clears outputs at once ----
        @(posedge clk); #1;
        addr = 32'h20; rd_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst resp rd_valid", 32'(rd_valid_a[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("rst resp outputs", any_out(1), 32'd0);
        rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
